gp_reg_file: RTL and testbench
==============================

# gp_reg_file

Parametrised general-purpose register file for the DECODE stage, replacing the fixed 32x32 register block. It provides two combinational read ports (rs/rt → A/B), one clocked write port from WRITEBACK, write-to-read bypass, and a hard-wired zero register. It also keeps a per-register pending-write scoreboard so DECODE can detect load-use and long-latency hazards without a separate hazard table.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- regwrite  input  1  write enable for the write port
- rd  input  ADDR_W  write address
- writedata  input  DATA_W  write data
- rs  input  ADDR_W  read port A address
- rt  input  ADDR_W  read port B address
- A  output  DATA_W  read data for rs (combinational)
- B  output  DATA_W  read data for rt (combinational)
- busy_set  input  1  mark busy_addr as having a pending write (issued producer)
- busy_addr  input  ADDR_W  register to mark pending
- rs_busy  output  1  rs has an unresolved pending write
- rt_busy  output  1  rt has an unresolved pending write
- busy_cnt  output  ADDR_W+1  number of registers currently marked pending

## Operation
- Storage: NUM_REGS x DATA_W flops plus NUM_REGS pending bits. Register 0 is not stored; it always reads 0 and is never pending.
- Write: at rising clk, if regwrite && rd != 0 && !rst, reg[rd] <= writedata. Writes to rd = 0 are discarded.
- Read: A = (rs == 0) ? 0 : (BYPASS && regwrite && rd == rs) ? writedata : reg[rs]. B follows the same rule with rt. Both ports are independent, and rs == rt is legal.
- Scoreboard, per register r != 0, evaluated at rising clk:
  - set if busy_set && busy_addr == r
  - else clear if regwrite && rd == r
  - else hold
  - Simultaneous set and clear on the same r: set wins, because the new producer supersedes the completing one.
- busy_set with busy_addr = 0 is ignored.
- rs_busy = pending[rs] && !(BYPASS && regwrite && rd == rs). The bypassed write resolves the hazard in the same cycle. rt_busy follows the same rule. For rs = 0 or rt = 0 the flag is 0.
- busy_cnt tracks the population count of pending bits. It is registered and updated with the same edge:
  - +1 for a set on a non-pending register
  - −1 for a clear on a pending register
  - net 0 when both occur on different registers
  - It never exceeds NUM_REGS−1.
- Reset (rst high at rising clk): all registers <= 0, all pending bits <= 0, busy_cnt <= 0. Reset overrides regwrite and busy_set in the same cycle.

## Timing
- Read latency 0 cycles (combinational from rs/rt/regwrite/rd/writedata).
- Write latency: data visible at A/B on the cycle it is presented (BYPASS = 1), or from the cycle after the edge (BYPASS = 0).
- Scoreboard: pending visible on rs_busy/rt_busy the cycle after busy_set. It is cleared the cycle after the matching write, or combinationally masked in the write cycle when BYPASS = 1.
- Output values after reset: A = 0, B = 0, rs_busy = 0, rt_busy = 0, busy_cnt = 0.
- Reset mid-operation: any pending writes are forgotten. A writeback arriving after reset still writes the register and leaves pending clear.
- No X propagation: uninitialised state is not allowed, because reset clears every location.

## Test plan
- Reset, then read all 32 addresses → A = B = 0 and busy_cnt = 0. Write 0xDEADBEEF to r0 → A reads 0 with rs = 0.
- Write r5 = 0x12345678 (regwrite = 1, rd = 5) with rs = 5 in the same cycle → A = 0x12345678 in that cycle (BYPASS = 1). With BYPASS = 0, A shows the old value (0) in that cycle and 0x12345678 the cycle after. Set rs = rt = 5 → A = B.
- busy_set on r7 → next cycle: rt = 7 gives rt_busy = 1 and busy_cnt = 1. Write r7 = 0xA5A5A5A5 → rt_busy = 0 in the write cycle (BYPASS = 1), and next cycle busy_cnt = 0.
- In the same cycle: busy_set r9 and regwrite rd = 9 while r9 is already pending → r9 stays pending and busy_cnt unchanged. In the same cycle: busy_set r3 and clear r4 (both pending beforehand except r3) → busy_cnt unchanged.
- Mark r1..r31 pending one per cycle → busy_cnt = 31. busy_set r0 → no change. Assert rst → next cycle busy_cnt = 0, all busy flags 0, all registers read 0.
- With DATA_W = 64, ADDR_W = 3: write r7 = 0xFFFF_0000_FFFF_0000 → it reads back exactly. rd = 8 is not representable (3-bit address), so address wrap is checked: writes cover r1..r7 only.

Source files
------------

// File: rtl/gp_reg_file.sv
// Parametrised DECODE-stage register file: two combinational read ports, one write port,
// optional write-to-read bypass, hard-wired zero register and a pending-write scoreboard.
module gp_reg_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] writedata,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned NumRegs = 1 << ADDR_W;
    localparam int unsigned CntW    = ADDR_W + 1;
    localparam bit          Byp     = (BYPASS != 0);

    logic [DATA_W-1:0]  regs_q [NumRegs];
    logic [NumRegs-1:0] pending_q, pending_d;
    logic [CntW-1:0]    busy_cnt_q, busy_cnt_d;

    logic wr_en, set_en, cnt_inc, cnt_dec, byp_a, byp_b;

    assign wr_en  = regwrite && (rd != '0);
    assign set_en = busy_set && (busy_addr != '0);

    // Set is applied after clear so a new producer supersedes the completing write.
    always_comb begin
        pending_d = pending_q;
        if (wr_en) begin
            pending_d[rd] = 1'b0;
        end
        if (set_en) begin
            pending_d[busy_addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_inc    = set_en && !pending_q[busy_addr];
        cnt_dec    = wr_en && pending_q[rd] && !(set_en && (busy_addr == rd));
        busy_cnt_d = busy_cnt_q + CntW'(cnt_inc) - CntW'(cnt_dec);
    end

    always_comb begin
        byp_a = Byp && regwrite && (rd == rs);
        byp_b = Byp && regwrite && (rd == rt);

        if (rs == '0) begin
            A = '0;
        end else if (byp_a) begin
            A = writedata;
        end else begin
            A = regs_q[rs];
        end

        if (rt == '0) begin
            B = '0;
        end else if (byp_b) begin
            B = writedata;
        end else begin
            B = regs_q[rt];
        end

        // Bit 0 of pending_q is never set, so r0 never reports busy.
        rs_busy = pending_q[rs] && !byp_a;
        rt_busy = pending_q[rt] && !byp_b;
    end

    assign busy_cnt = busy_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '{default: '0};
            pending_q  <= '0;
            busy_cnt_q <= '0;
        end else begin
            if (wr_en) begin
                regs_q[rd] <= writedata;
            end
            pending_q  <= pending_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

endmodule

// File: tb/tb_gp_reg_file.sv
// Scoreboard bench for gp_reg_file: a 32x32 bypassing instance and a 64-bit, 8-entry
// non-bypassing instance share one stimulus stream and are checked against an array model.
module tb_gp_reg_file;

    logic        clk = 1'b0;
    logic        rst, regwrite, busy_set;
    logic [4:0]  rd, rs, rt, busy_addr;
    logic [63:0] writedata;

    logic [31:0] a0, b0;
    logic        rsb0, rtb0;
    logic [5:0]  cnt0;
    logic [63:0] a1, b1;
    logic        rsb1, rtb1;
    logic [3:0]  cnt1;

    always #5 clk = ~clk;

    gp_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .regwrite  (regwrite),
        .rd        (rd),
        .writedata (writedata[31:0]),
        .rs        (rs),
        .rt        (rt),
        .A         (a0),
        .B         (b0),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .rs_busy   (rsb0),
        .rt_busy   (rtb0),
        .busy_cnt  (cnt0)
    );

    gp_reg_file #(.DATA_W(64), .ADDR_W(3), .BYPASS(0)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .regwrite  (regwrite),
        .rd        (rd[2:0]),
        .writedata (writedata),
        .rs        (rs[2:0]),
        .rt        (rt[2:0]),
        .A         (a1),
        .B         (b1),
        .busy_set  (busy_set),
        .busy_addr (busy_addr[2:0]),
        .rs_busy   (rsb1),
        .rt_busy   (rtb1),
        .busy_cnt  (cnt1)
    );

    typedef struct {
        int          inst;
        logic [63:0] a;
        logic [63:0] b;
        logic        rsb;
        logic        rtb;
        int          cnt;
    } port_t;

    port_t       exp_q[$];
    logic [63:0] mem  [2][32];
    bit          pend [2][32];
    int          n_vec = 0;
    int          n_bad = 0;

    function automatic int amask(input int k);
        return (k == 0) ? 31 : 7;
    endfunction

    function automatic logic [63:0] dmask(input int k, input logic [63:0] v);
        return (k == 0) ? {32'h0, v[31:0]} : v;
    endfunction

    function automatic port_t predict(input int k);
        port_t e;
        int    ra, rb, w, c;
        bit    byp_a, byp_b;
        ra    = int'(rs) & amask(k);
        rb    = int'(rt) & amask(k);
        w     = int'(rd) & amask(k);
        byp_a = (k == 0) && regwrite && (w == ra);
        byp_b = (k == 0) && regwrite && (w == rb);
        e.inst = k;
        e.a    = (ra == 0) ? 64'h0 : byp_a ? dmask(k, writedata) : mem[k][ra];
        e.b    = (rb == 0) ? 64'h0 : byp_b ? dmask(k, writedata) : mem[k][rb];
        e.rsb  = (ra != 0) && pend[k][ra] && !byp_a;
        e.rtb  = (rb != 0) && pend[k][rb] && !byp_b;
        c = 0;
        for (int i = 0; i <= amask(k); i++) c += pend[k][i] ? 1 : 0;
        e.cnt = c;
        return e;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 32; i++) begin
                mem[k][i]  = 64'h0;
                pend[k][i] = 1'b0;
            end
    endtask

    task automatic model_edge();
        int w, s;
        if (rst) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            w = int'(rd) & amask(k);
            s = int'(busy_addr) & amask(k);
            if (regwrite && w != 0) begin
                mem[k][w]  = dmask(k, writedata);
                pend[k][w] = 1'b0;
            end
            if (busy_set && s != 0) pend[k][s] = 1'b1;
        end
    endtask

    task automatic drive(input logic r, input logic rw, input logic [4:0] d,
                         input logic [63:0] wd, input logic [4:0] s, input logic [4:0] t,
                         input logic bs, input logic [4:0] ba);
        @(negedge clk);
        rst       = r;
        regwrite  = rw;
        rd        = d;
        writedata = wd;
        rs        = s;
        rt        = t;
        busy_set  = bs;
        busy_addr = ba;
        exp_q.push_back(predict(0));
        exp_q.push_back(predict(1));
        model_edge();
    endtask

    task automatic chk(input string name, input int k, input logic [63:0] got,
                       input logic [63:0] want);
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s inst%0d t=%0t got %h want %h", name, k, $time, got, want);
        end
    endtask

    // Outputs are combinational per cycle; sample mid-low-phase, after the driver settles.
    initial begin
        port_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (e.inst == 0) begin
                    chk("A", 0, {32'h0, a0}, e.a);
                    chk("B", 0, {32'h0, b0}, e.b);
                    chk("rs_busy", 0, {63'h0, rsb0}, {63'h0, e.rsb});
                    chk("rt_busy", 0, {63'h0, rtb0}, {63'h0, e.rtb});
                    chk("busy_cnt", 0, {58'h0, cnt0}, 64'(e.cnt));
                end else begin
                    chk("A", 1, a1, e.a);
                    chk("B", 1, b1, e.b);
                    chk("rs_busy", 1, {63'h0, rsb1}, {63'h0, e.rsb});
                    chk("rt_busy", 1, {63'h0, rtb1}, {63'h0, e.rtb});
                    chk("busy_cnt", 1, {60'h0, cnt1}, 64'(e.cnt));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog t=%0t got no end want end", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; regwrite = 1'b0; rd = '0; writedata = '0;
        rs = '0; rt = '0; busy_set = 1'b0; busy_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);

        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
        drive(0, 1, 0, 64'hDEADBEEF, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 5, 64'h12345678, 5, 5, 0, 0);
        drive(0, 0, 0, 0, 5, 5, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 7);
        drive(0, 0, 0, 0, 0, 7, 0, 0);
        drive(0, 1, 7, 64'hA5A5A5A5, 7, 7, 0, 0);
        drive(0, 0, 0, 0, 7, 7, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 9);
        drive(0, 0, 0, 0, 9, 4, 1, 4);
        drive(0, 1, 9, 64'h99, 9, 4, 1, 9);
        drive(0, 1, 4, 64'h44, 3, 4, 1, 3);
        drive(0, 0, 0, 0, 3, 4, 0, 0);
        for (int i = 1; i < 32; i++) drive(0, 0, 0, 0, 5'(i), 5'(i - 1), 1, 5'(i));
        drive(0, 0, 0, 0, 1, 31, 1, 0);
        drive(0, 0, 0, 0, 9, 7, 0, 0);
        drive(1, 1, 6, 64'h66, 6, 7, 1, 6);
        for (int i = 0; i < 32; i++) drive(0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
        drive(0, 1, 7, 64'hFFFF_0000_FFFF_0000, 7, 7, 0, 0);
        drive(0, 1, 8, 64'h0BAD_0BAD_0BAD_0BAD, 7, 0, 0, 0);
        drive(0, 0, 0, 0, 7, 8, 0, 0);

        for (int n = 0; n < 2000; n++) begin
            logic       r, rw, bs;
            logic [4:0] d, s, t, ba;
            r  = ($urandom_range(0, 99) == 0);
            rw = $urandom_range(0, 1);
            d  = 5'($urandom);
            s  = ($urandom_range(0, 2) == 0) ? d : 5'($urandom);
            t  = ($urandom_range(0, 2) == 0) ? s : 5'($urandom);
            bs = ($urandom_range(0, 2) == 0);
            ba = ($urandom_range(0, 3) == 0) ? d : 5'($urandom);
            drive(r, rw, d, {$urandom, $urandom}, s, t, bs, ba);
        end

        @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
